// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response channel bundle between the CPU core (master) and the data memory (slave)
// ports: req_valid/req_ready/req_we/req_addr/req_wdata/req_be request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [31:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word memory answering CPU load/store requests with wait states, byte enables and error reporting
// ports: clk; reset (async, active-high); bus (slave side of request/response channels); txn_count (completed responses, wraps)
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus,
  output logic [7:0] txn_count
);
  localparam int AW = $clog2(WORDS);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic c_we, a_we;
  logic [31:0] c_addr, a_addr;
  logic [DATA_WIDTH-1:0] c_wdata, a_wdata;
  logic [BW-1:0] c_be, a_be;
  logic accept, access, err;
  logic [AW-1:0] idx;
  logic [DATA_WIDTH-1:0] rdata;
  logic rsp_err_q;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  assign accept = state == IDLE && bus.req_valid;
  assign access = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  // with no wait states the access lands on the accept edge, before the request is captured
  assign a_we = state == IDLE ? bus.req_we : c_we;
  assign a_addr = state == IDLE ? bus.req_addr : c_addr;
  assign a_wdata = state == IDLE ? bus.req_wdata : c_wdata;
  assign a_be = state == IDLE ? bus.req_be : c_be;
  assign idx = a_addr[AW+1:2];
  assign err = |a_addr[1:0] || a_addr >= 32'(WORDS * 4);
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err = rsp_err_q;
  always_comb begin
    state_n = state;
    if (accept) state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd0) state_n = RESP;
    else if (state == RESP && bus.rsp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      txn_count <= '0;
      rdata <= '0;
      rsp_err_q <= 1'b0;
      c_we <= 1'b0;
      c_addr <= '0;
      c_wdata <= '0;
      c_be <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        c_we <= bus.req_we;
        c_addr <= bus.req_addr;
        c_wdata <= bus.req_wdata;
        c_be <= bus.req_be;
        cnt <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (access) begin
        rsp_err_q <= err;
        rdata <= err || a_we ? '0 : mem[idx];
      end
      if (state == RESP && bus.rsp_ready) txn_count <= txn_count + 8'd1;
    end
  // memory contents survive reset, so the array has no reset branch
  always_ff @(posedge clk)
    if (access && a_we && !err)
      for (int i = 0; i < BW; i++)
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers load/store requests from the CPU core over a valid/ready request channel and a valid/ready response channel. It supports programmable wait states, per-byte write enables, and error reporting for misaligned or out-of-range addresses. The block is the memory-side end of the core's load/store path and replaces the core's internal zero-latency data array.

## Interface
- `DATA_WIDTH`, 32, data word width; fixed at 32, with byte enables sized `DATA_WIDTH/8`
- `WORDS`, 8, number of memory words
- `WAIT_CYCLES`, 2, wait states inserted before the access is performed; legal range 0..15
- `clk`  in  1  sole clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data
- `req_be`  in  4  byte enables for a store; bit i enables byte lane [8i+7:8i]; ignored on a load
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes the response
- `rsp_rdata`  out  32  load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned or out-of-range access
- `txn_count`  out  8  count of completed responses; wraps

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready` = 1 only in IDLE. `rsp_valid` = 1 only in RESP.
- **Accept:** `req_valid && req_ready` at a rising edge.
  - Captures `req_we`, `req_addr`, `req_wdata`, `req_be`.
  - If `WAIT_CYCLES` = 0: performs the access at that edge and goes to RESP.
  - Otherwise: goes to WAIT with counter = `WAIT_CYCLES`-1.
- **WAIT:**
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access and go to RESP.
- **Access:**
  - Word index = `addr[clog2(WORDS)+1:2]`.
  - Error if `addr[1:0]` ≠ 0 or `addr` ≥ `WORDS`*4.
  - Error: no memory write, `rsp_rdata` = 0, `rsp_err` = 1.
  - Store: writes only the enabled byte lanes; `rsp_rdata` = 0; `rsp_err` = 0.
  - Load: registers `mem[index]` into `rsp_rdata`; `rsp_err` = 0.
- **RESP:**
  - Holds `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: goes to IDLE and increments `txn_count` (255 → 0).
- `req_valid` outside IDLE is ignored; the requester must keep the request asserted until accepted.
- Only one transaction is outstanding at a time. There is no request queue.

## Timing
- **Reset values (asynchronous):** state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `txn_count` 0, wait counter 0. Memory contents are not cleared.
- **Latency:** with the accept edge at the end of cycle 0, `rsp_valid` is first high in cycle `WAIT_CYCLES`+1.
- **Response-to-next-accept:** the response handshake edge returns the block to IDLE. The earliest next accept is the following edge, so best-case throughput is one transaction per `WAIT_CYCLES`+2 cycles.
- A store's write to memory occurs at the access edge. A load issued after the store's response always sees the new data.
- **Reset mid-operation:** the in-flight transaction is dropped with no response.
  - If reset arrives before the access edge, memory is unchanged.
  - If it arrives after, the store persists.
- **Partial byte enables:** `req_be` = 0000 on a store is a legal no-op write that still returns a response with `rsp_err` = 0.
- **Counter width:** 4 bits. `WAIT_CYCLES` = 15 gives 15 WAIT cycles.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs take their reset values immediately without a clock edge. Release → `req_ready` = 1 and `txn_count` = 0.
- **Store/load, W=2:** store 0xDEADBEEF to 0x08 with be = 1111, then load 0x08.
  - Each `rsp_valid` is first high 3 cycles after its accept.
  - Load returns `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0.
  - `txn_count` = 2.
- **Byte enables:** over 0xDEADBEEF at 0x08, store 0x11223344 with be = 0101 → load 0x08 returns 0xDE22BE44.
- **Errors:**
  - Load 0x20 → `rsp_err` = 1, `rsp_rdata` = 0.
  - Store 0xFFFFFFFF to 0x05 → `rsp_err` = 1.
  - A subsequent load of 0x04 returns its prior value unchanged.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles during RESP while driving a new `req_valid`.
  - `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable and `req_ready` stays 0.
  - The new request is accepted only after the response handshake.
- **Reset mid-WAIT and counter wrap:**
  - Reset during WAIT of a store to 0x00 → a load of 0x00 returns the old value.
  - With `WAIT_CYCLES` = 0 and `rsp_ready` = 1, 256 back-to-back loads → `txn_count` wraps to 0.
